// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
//   Shared types and constants for the DMA engine.
//   - t_dma_mode        : descriptor transfer mode
//   - t_disp_state_idx  : bit position of each dispatcher state in the one-hot
//                         state vector
//   - t_disp_state      : one-hot dispatcher state encoding (DISP_STATE_W bits)
//   - ERR_*             : bit positions inside the dispatcher err_cause vector
//   - mode_is_valid()   : true for modes that actually move data
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int DISP_STATE_W = 6;

    typedef enum logic [1:0] {
        STAND_BY    = 2'd0,
        HOST_TO_DDR = 2'd1,
        DDR_TO_HOST = 2'd2,
        DDR_TO_DDR  = 2'd3
    } t_dma_mode;

    typedef enum int {
        IDX_IDLE     = 0,
        IDX_CHECK    = 1,
        IDX_LAUNCH   = 2,
        IDX_RUN      = 3,
        IDX_COMPLETE = 4,
        IDX_ERROR    = 5
    } t_disp_state_idx;

    typedef enum logic [DISP_STATE_W-1:0] {
        ST_IDLE     = 6'b000001,
        ST_CHECK    = 6'b000010,
        ST_LAUNCH   = 6'b000100,
        ST_RUN      = 6'b001000,
        ST_COMPLETE = 6'b010000,
        ST_ERROR    = 6'b100000
    } t_disp_state;

    localparam int ERR_RD       = 0;
    localparam int ERR_WR       = 1;
    localparam int ERR_TIMEOUT  = 2;
    localparam int ERR_BAD_DESC = 3;

    // STAND_BY is a parking mode; a descriptor carrying it is malformed.
    function automatic logic mode_is_valid(input logic [1:0] mode);
        return mode != STAND_BY;
    endfunction

endpackage

// File: rtl/dma_watchdog.sv
// -----------------------------------------------------------------------------
// dma_watchdog
//   Cycle counter that flags when an operation has been running too long.
//   Ports:
//     clk, reset_n  : clock, synchronous active-low reset
//     clear         : restart the count from zero (wins over enable)
//     enable        : count this cycle
//     limit         : expiry threshold in cycles; 0 means never expire
//     expire        : high during the limit-th enabled cycle after a clear
// -----------------------------------------------------------------------------
module dma_watchdog #(
    parameter int TIMEOUT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expire
);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count shows 0 in the first enabled cycle, so limit-1 marks the
    // limit-th cycle; the owner reacts in that same cycle.
    assign expire = enable && (limit != '0) && (count_q == limit - TIMEOUT_W'(1));

endmodule

// File: rtl/dma_descriptor_dispatcher.sv
// -----------------------------------------------------------------------------
// dma_descriptor_dispatcher
//   Runs one DMA descriptor at a time: pops it from the show-ahead descriptor
//   FIFO, validates it, launches the read-source and write-destination FSMs,
//   and waits for both to report done. Completions are counted and can raise a
//   one-cycle irq. Errors and watchdog timeouts park the block in ERROR until
//   the CSR block pulses csr_reset_dispatcher.
//   Ports:
//     clk, reset_n                 : clock, synchronous active-low reset
//     desc_not_empty, desc_*       : head of the descriptor FIFO
//     desc_rd_en                   : one-cycle FIFO pop
//     rd_go, wr_go                 : one-cycle launch pulses to the FSMs
//     cur_*                        : descriptor currently being executed
//     rd_done, wr_done             : done pulses from the FSMs
//     rd_err, wr_err               : response-error pulses from the FSMs
//     csr_halt                     : stop taking new descriptors
//     csr_reset_dispatcher         : abort and clear the error state
//     csr_timeout                  : watchdog limit in cycles, 0 disables
//     busy, stopped_on_error       : status (not IDLE / in ERROR)
//     err_cause                    : sticky {bad_desc, timeout, wr_err, rd_err}
//     done_cnt                     : completed-descriptor counter (wraps)
//     irq                          : one-cycle completion pulse
//     state_o                      : one-hot state for CSR readback
// -----------------------------------------------------------------------------
module dma_descriptor_dispatcher
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int LENGTH_W  = 24,
    parameter int TIMEOUT_W = 32,
    parameter int CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    desc_not_empty,
    input  logic [ADDR_W-1:0]       desc_src_addr,
    input  logic [ADDR_W-1:0]       desc_dest_addr,
    input  logic [LENGTH_W-1:0]     desc_length,
    input  logic [1:0]              desc_mode,
    input  logic                    desc_irq_en,
    output logic                    desc_rd_en,

    output logic                    rd_go,
    output logic                    wr_go,
    output logic [ADDR_W-1:0]       cur_src_addr,
    output logic [ADDR_W-1:0]       cur_dest_addr,
    output logic [LENGTH_W-1:0]     cur_length,
    output logic [1:0]              cur_mode,

    input  logic                    rd_done,
    input  logic                    wr_done,
    input  logic                    rd_err,
    input  logic                    wr_err,

    input  logic                    csr_halt,
    input  logic                    csr_reset_dispatcher,
    input  logic [TIMEOUT_W-1:0]    csr_timeout,

    output logic                    busy,
    output logic                    stopped_on_error,
    output logic [3:0]              err_cause,
    output logic [CNT_W-1:0]        done_cnt,
    output logic                    irq,
    output logic [DISP_STATE_W-1:0] state_o
);

    localparam logic [DISP_STATE_W-1:0] S_IDLE     = ST_IDLE;
    localparam logic [DISP_STATE_W-1:0] S_CHECK    = ST_CHECK;
    localparam logic [DISP_STATE_W-1:0] S_LAUNCH   = ST_LAUNCH;
    localparam logic [DISP_STATE_W-1:0] S_RUN      = ST_RUN;
    localparam logic [DISP_STATE_W-1:0] S_COMPLETE = ST_COMPLETE;
    localparam logic [DISP_STATE_W-1:0] S_ERROR    = ST_ERROR;

    logic [DISP_STATE_W-1:0] state_q,         state_d;
    logic [ADDR_W-1:0]       cur_src_addr_q,  cur_src_addr_d;
    logic [ADDR_W-1:0]       cur_dest_addr_q, cur_dest_addr_d;
    logic [LENGTH_W-1:0]     cur_length_q,    cur_length_d;
    logic [1:0]              cur_mode_q,      cur_mode_d;
    logic                    cur_irq_en_q,    cur_irq_en_d;
    logic [3:0]              err_cause_q,     err_cause_d;
    logic [CNT_W-1:0]        done_cnt_q,      done_cnt_d;
    logic                    rd_seen_q,       rd_seen_d;
    logic                    wr_seen_q,       wr_seen_d;

    logic                    abort;
    logic                    pop;
    logic                    launch;
    logic                    irq_pulse;
    logic                    wd_clear;
    logic                    wd_enable;
    logic                    wd_expire;
    logic                    rd_finished;
    logic                    wr_finished;

    // Holding abort during reset keeps every pulse low even if the FIFO
    // already shows data while the flops are being reset.
    assign abort = !reset_n || csr_reset_dispatcher;

    assign wd_enable = state_q[IDX_RUN];

    // A done arriving in the same cycle as the other side's flag finishes
    // the descriptor without waiting for the flag to register.
    assign rd_finished = rd_seen_q || rd_done;
    assign wr_finished = wr_seen_q || wr_done;

    dma_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .limit   (csr_timeout),
        .expire  (wd_expire)
    );

    // Next-state and datapath logic. Abort overrides every transition and
    // suppresses every pulse; the done counter and latched descriptor
    // survive it so software can still inspect what was running.
    always_comb begin
        state_d         = state_q;
        cur_src_addr_d  = cur_src_addr_q;
        cur_dest_addr_d = cur_dest_addr_q;
        cur_length_d    = cur_length_q;
        cur_mode_d      = cur_mode_q;
        cur_irq_en_d    = cur_irq_en_q;
        err_cause_d     = err_cause_q;
        done_cnt_d      = done_cnt_q;
        rd_seen_d       = rd_seen_q;
        wr_seen_d       = wr_seen_q;
        pop             = 1'b0;
        launch          = 1'b0;
        irq_pulse       = 1'b0;
        wd_clear        = 1'b0;

        if (abort) begin
            state_d     = S_IDLE;
            err_cause_d = '0;
            rd_seen_d   = 1'b0;
            wr_seen_d   = 1'b0;
            wd_clear    = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (desc_not_empty && !csr_halt) begin
                        pop             = 1'b1;
                        cur_src_addr_d  = desc_src_addr;
                        cur_dest_addr_d = desc_dest_addr;
                        cur_length_d    = desc_length;
                        cur_mode_d      = desc_mode;
                        cur_irq_en_d    = desc_irq_en;
                        state_d         = S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (!mode_is_valid(cur_mode_q)) begin
                        err_cause_d[ERR_BAD_DESC] = 1'b1;
                        state_d                   = S_ERROR;
                    end else if (cur_length_q == '0) begin
                        state_d = S_COMPLETE;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    launch    = 1'b1;
                    rd_seen_d = 1'b0;
                    wr_seen_d = 1'b0;
                    wd_clear  = 1'b1;
                    state_d   = S_RUN;
                end

                S_RUN: begin
                    rd_seen_d = rd_finished;
                    wr_seen_d = wr_finished;
                    if (rd_err || wr_err) begin
                        err_cause_d[ERR_RD] = err_cause_q[ERR_RD] | rd_err;
                        err_cause_d[ERR_WR] = err_cause_q[ERR_WR] | wr_err;
                        state_d             = S_ERROR;
                    end else if (wd_expire) begin
                        err_cause_d[ERR_TIMEOUT] = 1'b1;
                        state_d                  = S_ERROR;
                    end else if (rd_finished && wr_finished) begin
                        state_d = S_COMPLETE;
                    end
                end

                S_COMPLETE: begin
                    done_cnt_d = done_cnt_q + CNT_W'(1);
                    irq_pulse  = cur_irq_en_q;
                    state_d    = S_IDLE;
                end

                S_ERROR: begin
                    state_d = S_ERROR;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            cur_src_addr_q  <= '0;
            cur_dest_addr_q <= '0;
            cur_length_q    <= '0;
            cur_mode_q      <= '0;
            cur_irq_en_q    <= 1'b0;
            err_cause_q     <= '0;
            done_cnt_q      <= '0;
            rd_seen_q       <= 1'b0;
            wr_seen_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_src_addr_q  <= cur_src_addr_d;
            cur_dest_addr_q <= cur_dest_addr_d;
            cur_length_q    <= cur_length_d;
            cur_mode_q      <= cur_mode_d;
            cur_irq_en_q    <= cur_irq_en_d;
            err_cause_q     <= err_cause_d;
            done_cnt_q      <= done_cnt_d;
            rd_seen_q       <= rd_seen_d;
            wr_seen_q       <= wr_seen_d;
        end
    end

    assign desc_rd_en       = pop;
    assign rd_go            = launch;
    assign wr_go            = launch;
    assign irq              = irq_pulse;
    assign cur_src_addr     = cur_src_addr_q;
    assign cur_dest_addr    = cur_dest_addr_q;
    assign cur_length       = cur_length_q;
    assign cur_mode         = cur_mode_q;
    assign busy             = !state_q[IDX_IDLE];
    assign stopped_on_error = state_q[IDX_ERROR];
    assign err_cause        = err_cause_q;
    assign done_cnt         = done_cnt_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_dma_descriptor_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_dma_descriptor_dispatcher
//   Directed bench for the descriptor dispatcher. A small show-ahead FIFO model
//   feeds descriptors; the done/err pulses of the datapath FSMs are driven by
//   hand. Pulse outputs are counted on the falling edge.
// -----------------------------------------------------------------------------
module tb_dma_descriptor_dispatcher;

    localparam logic [5:0] TB_IDLE     = 6'b000001;
    localparam logic [5:0] TB_CHECK    = 6'b000010;
    localparam logic [5:0] TB_LAUNCH   = 6'b000100;
    localparam logic [5:0] TB_RUN      = 6'b001000;
    localparam logic [5:0] TB_COMPLETE = 6'b010000;
    localparam logic [5:0] TB_ERROR    = 6'b100000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        desc_not_empty;
    logic [63:0] desc_src_addr;
    logic [63:0] desc_dest_addr;
    logic [23:0] desc_length;
    logic [1:0]  desc_mode;
    logic        desc_irq_en;
    logic        desc_rd_en;
    logic        rd_go, wr_go;
    logic [63:0] cur_src_addr, cur_dest_addr;
    logic [23:0] cur_length;
    logic [1:0]  cur_mode;
    logic        rd_done, wr_done, rd_err, wr_err;
    logic        csr_halt, csr_reset_dispatcher;
    logic [31:0] csr_timeout;
    logic        busy, stopped_on_error;
    logic [3:0]  err_cause;
    logic [31:0] done_cnt;
    logic        irq;
    logic [5:0]  state_o;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int rd_go_cnt = 0;
    int wr_go_cnt = 0;
    int irq_cnt = 0;
    int pop_cnt = 0;

    // Descriptor FIFO model (show-ahead, 16 entries)
    logic [63:0] q_src  [16];
    logic [63:0] q_dest [16];
    logic [23:0] q_len  [16];
    logic [1:0]  q_mode [16];
    logic        q_irq  [16];
    logic [3:0]  fifo_rd = 4'd0;
    logic [3:0]  fifo_wr = 4'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (desc_rd_en) fifo_rd <= fifo_rd + 4'd1;
    end

    assign desc_not_empty = (fifo_rd != fifo_wr);
    assign desc_src_addr  = q_src[fifo_rd];
    assign desc_dest_addr = q_dest[fifo_rd];
    assign desc_length    = q_len[fifo_rd];
    assign desc_mode      = q_mode[fifo_rd];
    assign desc_irq_en    = q_irq[fifo_rd];

    always @(negedge clk) begin
        if (rd_go)      rd_go_cnt <= rd_go_cnt + 1;
        if (wr_go)      wr_go_cnt <= wr_go_cnt + 1;
        if (irq)        irq_cnt   <= irq_cnt + 1;
        if (desc_rd_en) pop_cnt   <= pop_cnt + 1;
    end

    dma_descriptor_dispatcher dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .desc_not_empty       (desc_not_empty),
        .desc_src_addr        (desc_src_addr),
        .desc_dest_addr       (desc_dest_addr),
        .desc_length          (desc_length),
        .desc_mode            (desc_mode),
        .desc_irq_en          (desc_irq_en),
        .desc_rd_en           (desc_rd_en),
        .rd_go                (rd_go),
        .wr_go                (wr_go),
        .cur_src_addr         (cur_src_addr),
        .cur_dest_addr        (cur_dest_addr),
        .cur_length           (cur_length),
        .cur_mode             (cur_mode),
        .rd_done              (rd_done),
        .wr_done              (wr_done),
        .rd_err               (rd_err),
        .wr_err               (wr_err),
        .csr_halt             (csr_halt),
        .csr_reset_dispatcher (csr_reset_dispatcher),
        .csr_timeout          (csr_timeout),
        .busy                 (busy),
        .stopped_on_error     (stopped_on_error),
        .err_cause            (err_cause),
        .done_cnt             (done_cnt),
        .irq                  (irq),
        .state_o              (state_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] s, input logic [63:0] d, input logic [23:0] l,
                        input logic [1:0] m, input logic ie);
        q_src[fifo_wr]  = s;
        q_dest[fifo_wr] = d;
        q_len[fifo_wr]  = l;
        q_mode[fifo_wr] = m;
        q_irq[fifo_wr]  = ie;
        fifo_wr         = fifo_wr + 4'd1;
    endtask

    task automatic wait_go(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (rd_go === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rd_done = 1'b0; wr_done = 1'b0; rd_err = 1'b0; wr_err = 1'b0;
        csr_halt = 1'b0; csr_reset_dispatcher = 1'b0; csr_timeout = 32'd0;
        for (int i = 0; i < 16; i++) begin
            q_src[i] = '0; q_dest[i] = '0; q_len[i] = '0; q_mode[i] = '0; q_irq[i] = 1'b0;
        end
        repeat (3) tick();
        checks++; if (state_o !== TB_IDLE) begin errors++; $display("[TB] FAIL reset_state: got %b expected %b", state_o, TB_IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (stopped_on_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_stopped: got %b expected 0", stopped_on_error); end
        checks++; if (err_cause !== 4'b0000) begin errors++; $display("[TB] FAIL reset_err_cause: got %b expected 0000", err_cause); end
        checks++; if (done_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_done_cnt: got %0d expected 0", done_cnt); end
        checks++; if (cur_length !== 24'd0 || cur_src_addr !== 64'd0) begin errors++; $display("[TB] FAIL reset_cur: got len %0d src %0h expected 0", cur_length, cur_src_addr); end
        checks++; if ({rd_go, wr_go, irq, desc_rd_en} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {rd_go, wr_go, irq, desc_rd_en}); end
        reset_n = 1'b1;
        tick();
    endtask

    // len=4 HOST_TO_DDR, rd_done 10 and wr_done 20 cycles after launch
    task automatic test_basic();
        int g0 = rd_go_cnt, w0 = wr_go_cnt, i0 = irq_cnt, p0 = pop_cnt;
        bit seen;
        push(64'h0000_1000_0000_1000, 64'h0000_2000_0000_2000, 24'd4, 2'd1, 1'b1);
        #1;
        checks++; if (desc_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL basic_pop: got %b expected 1", desc_rd_en); end
        wait_go(8, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL basic_launch: got no rd_go expected rd_go within 8 cycles"); end
        checks++; if (cur_length !== 24'd4 || cur_mode !== 2'd1) begin errors++; $display("[TB] FAIL basic_cur: got len %0d mode %0d expected len 4 mode 1", cur_length, cur_mode); end
        checks++; if (cur_src_addr !== 64'h0000_1000_0000_1000 || cur_dest_addr !== 64'h0000_2000_0000_2000) begin errors++; $display("[TB] FAIL basic_addr: got %h %h", cur_src_addr, cur_dest_addr); end
        repeat (10) tick();
        rd_done = 1'b1; tick(); rd_done = 1'b0;
        repeat (9) tick();
        checks++; if (state_o !== TB_RUN) begin errors++; $display("[TB] FAIL basic_wait_wr: got %b expected %b", state_o, TB_RUN); end
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        checks++; if (state_o !== TB_COMPLETE || irq !== 1'b1) begin errors++; $display("[TB] FAIL basic_complete: got state %b irq %b expected %b irq 1", state_o, irq, TB_COMPLETE); end
        tick();
        exp_done++;
        checks++; if (done_cnt !== 32'(exp_done) || busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_done: got cnt %0d busy %b expected cnt %0d busy 0", done_cnt, busy, exp_done); end
        checks++; if (rd_go_cnt - g0 != 1 || wr_go_cnt - w0 != 1 || irq_cnt - i0 != 1 || pop_cnt - p0 != 1) begin
            errors++; $display("[TB] FAIL basic_pulses: got rd_go %0d wr_go %0d irq %0d pop %0d expected 1 each", rd_go_cnt - g0, wr_go_cnt - w0, irq_cnt - i0, pop_cnt - p0);
        end
    endtask

    // both done pulses in one cycle, irq disabled
    task automatic test_same_cycle_done();
        int i0 = irq_cnt;
        bit seen;
        push(64'h3000, 64'h4000, 24'd8, 2'd3, 1'b0);
        wait_go(8, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL same_launch: got no rd_go expected rd_go within 8 cycles"); end
        tick(); tick();
        rd_done = 1'b1; wr_done = 1'b1; tick(); rd_done = 1'b0; wr_done = 1'b0;
        checks++; if (state_o !== TB_COMPLETE) begin errors++; $display("[TB] FAIL same_complete: got %b expected %b", state_o, TB_COMPLETE); end
        tick();
        exp_done++;
        checks++; if (done_cnt !== 32'(exp_done) || irq_cnt != i0) begin errors++; $display("[TB] FAIL same_done: got cnt %0d irqs %0d expected cnt %0d irqs 0", done_cnt, irq_cnt - i0, exp_done); end
    endtask

    // wr_err with rd_done, stray pulses in ERROR, then reset_dispatcher
    task automatic test_error_and_clear();
        int i0 = irq_cnt;
        bit seen;
        push(64'h5000, 64'h6000, 24'd4, 2'd2, 1'b1);
        wait_go(8, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL err_launch: got no rd_go expected rd_go within 8 cycles"); end
        tick(); tick();
        rd_done = 1'b1; wr_err = 1'b1; tick(); rd_done = 1'b0; wr_err = 1'b0;
        checks++; if (state_o !== TB_ERROR || stopped_on_error !== 1'b1) begin errors++; $display("[TB] FAIL err_state: got %b stopped %b expected %b stopped 1", state_o, stopped_on_error, TB_ERROR); end
        checks++; if (err_cause !== 4'b0010) begin errors++; $display("[TB] FAIL err_cause_wr: got %b expected 0010", err_cause); end
        rd_err = 1'b1; wr_done = 1'b1; tick(); rd_err = 1'b0; wr_done = 1'b0;
        repeat (3) tick();
        checks++; if (state_o !== TB_ERROR || err_cause !== 4'b0010) begin errors++; $display("[TB] FAIL err_hold: got %b cause %b expected %b cause 0010", state_o, err_cause, TB_ERROR); end
        checks++; if (done_cnt !== 32'(exp_done) || irq_cnt != i0) begin errors++; $display("[TB] FAIL err_no_irq: got cnt %0d irqs %0d expected cnt %0d irqs 0", done_cnt, irq_cnt - i0, exp_done); end
        csr_reset_dispatcher = 1'b1; tick(); csr_reset_dispatcher = 1'b0;
        checks++; if (state_o !== TB_IDLE || err_cause !== 4'b0000) begin errors++; $display("[TB] FAIL err_clear: got %b cause %b expected %b cause 0000", state_o, err_cause, TB_IDLE); end
        checks++; if (done_cnt !== 32'(exp_done) || cur_mode !== 2'd2) begin errors++; $display("[TB] FAIL err_keep: got cnt %0d mode %0d expected cnt %0d mode 2", done_cnt, cur_mode, exp_done); end
    endtask

    // watchdog fires on the 100th RUN cycle after launch
    task automatic test_timeout();
        bit seen;
        csr_timeout = 32'd100;
        push(64'h7000, 64'h8000, 24'd16, 2'd1, 1'b1);
        wait_go(8, seen);
        checks++; if (!seen) begin errors++; $display("[TB] FAIL to_launch: got no rd_go expected rd_go within 8 cycles"); end
        repeat (100) tick();
        checks++; if (state_o !== TB_RUN) begin errors++; $display("[TB] FAIL to_early: got %b expected %b", state_o, TB_RUN); end
        tick();
        checks++; if (state_o !== TB_ERROR || err_cause !== 4'b0100) begin errors++; $display("[TB] FAIL to_fire: got %b cause %b expected %b cause 0100", state_o, err_cause, TB_ERROR); end
        csr_reset_dispatcher = 1'b1; tick(); csr_reset_dispatcher = 1'b0;
        csr_timeout = 32'd0;
        checks++; if (state_o !== TB_IDLE) begin errors++; $display("[TB] FAIL to_clear: got %b expected %b", state_o, TB_IDLE); end
    endtask

    // STAND_BY descriptor, then a zero-length one whose first pop is blocked
    task automatic test_bad_and_zero_len();
        int g0 = rd_go_cnt, p0;
        push(64'h9000, 64'hA000, 24'd4, 2'd0, 1'b1);
        tick(); tick();
        checks++; if (state_o !== TB_ERROR || err_cause !== 4'b1000) begin errors++; $display("[TB] FAIL bad_desc: got %b cause %b expected %b cause 1000", state_o, err_cause, TB_ERROR); end
        csr_reset_dispatcher = 1'b1; tick();
        p0 = pop_cnt;
        push(64'hB000, 64'hC000, 24'd0, 2'd1, 1'b1);
        #1;
        checks++; if (desc_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL abort_pop: got %b expected 0", desc_rd_en); end
        tick();
        checks++; if (state_o !== TB_IDLE || pop_cnt != p0) begin errors++; $display("[TB] FAIL abort_idle: got %b pops %0d expected %b pops 0", state_o, pop_cnt - p0, TB_IDLE); end
        csr_reset_dispatcher = 1'b0;
        tick(); tick();
        checks++; if (state_o !== TB_COMPLETE || irq !== 1'b1) begin errors++; $display("[TB] FAIL zero_complete: got %b irq %b expected %b irq 1", state_o, irq, TB_COMPLETE); end
        tick();
        exp_done++;
        checks++; if (done_cnt !== 32'(exp_done) || rd_go_cnt != g0) begin errors++; $display("[TB] FAIL zero_done: got cnt %0d gos %0d expected cnt %0d gos 0", done_cnt, rd_go_cnt - g0, exp_done); end
    endtask

    // three queued descriptors, halt raised while the first runs
    task automatic test_halt();
        int p0 = pop_cnt;
        int base = exp_done;
        logic [63:0] want;
        bit seen;
        push(64'hA0A0, 64'h1111, 24'd2, 2'd1, 1'b1);
        push(64'hB0B0, 64'h2222, 24'd2, 2'd2, 1'b1);
        push(64'hC0C0, 64'h3333, 24'd2, 2'd3, 1'b1);
        wait_go(8, seen);
        checks++; if (!seen || cur_src_addr !== 64'hA0A0) begin errors++; $display("[TB] FAIL halt_first: got seen %b src %h expected seen 1 src a0a0", seen, cur_src_addr); end
        csr_halt = 1'b1;
        tick();
        rd_done = 1'b1; wr_done = 1'b1; tick(); rd_done = 1'b0; wr_done = 1'b0;
        tick();
        exp_done++;
        repeat (5) tick();
        checks++; if (busy !== 1'b0 || desc_rd_en !== 1'b0 || pop_cnt - p0 != 1) begin errors++; $display("[TB] FAIL halt_hold: got busy %b rd_en %b pops %0d expected 0 0 1", busy, desc_rd_en, pop_cnt - p0); end
        checks++; if (done_cnt !== 32'(exp_done)) begin errors++; $display("[TB] FAIL halt_first_done: got %0d expected %0d", done_cnt, exp_done); end
        csr_halt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            want = (k == 0) ? 64'hB0B0 : 64'hC0C0;
            wait_go(8, seen);
            checks++; if (!seen || cur_src_addr !== want) begin errors++; $display("[TB] FAIL halt_order%0d: got seen %b src %h expected seen 1 src %h", k, seen, cur_src_addr, want); end
            tick();
            rd_done = 1'b1; wr_done = 1'b1; tick(); rd_done = 1'b0; wr_done = 1'b0;
            tick();
            exp_done++;
        end
        checks++; if (done_cnt !== 32'(base + 3) || pop_cnt - p0 != 3 || desc_not_empty !== 1'b0) begin
            errors++; $display("[TB] FAIL halt_final: got cnt %0d pops %0d not_empty %b expected cnt %0d pops 3 not_empty 0", done_cnt, pop_cnt - p0, desc_not_empty, base + 3);
        end
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        test_reset();
        test_basic();
        test_same_cycle_done();
        test_error_and_clear();
        test_timeout();
        test_bad_and_zero_len();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
